// File: rtl/cache_line_fill_pkg.sv
// Shared definitions for the read-miss line-fill controller.
package cache_line_fill_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    INVAL  = 2'd1,
    FETCH  = 2'd2,
    COMMIT = 2'd3
  } fill_state_e;

endpackage

// File: rtl/cache_line_fill_bin_to_onehot.sv
// Binary way index to one-hot way enable decode.
module cache_line_fill_bin_to_onehot #(
  parameter int N_WAYS = 8,
  parameter int NWAY_W = $clog2(N_WAYS)
) (
  input  logic [NWAY_W-1:0] bin,
  output logic [N_WAYS-1:0] onehot
);

  for (genvar i = 0; i < N_WAYS; i++) begin : g_dec
    assign onehot[i] = (bin == NWAY_W'(i));
  end

endmodule

// File: rtl/cache_line_fill.sv
// Read-miss line fill: invalidate victim way, fetch the line word by word into
// its data memory, then commit the tag and update the replacement policy.
module cache_line_fill
  import cache_line_fill_pkg::*;
#(
  parameter int N_WAYS     = 8,
  parameter int NWAY_W     = $clog2(N_WAYS),
  parameter int LINE_OFF_W = 4,
  parameter int WORD_OFF_W = 3,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int TAG_W      = ADDR_W - LINE_OFF_W - WORD_OFF_W - $clog2(DATA_W/8)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  miss_req,
  input  logic [TAG_W-1:0]      miss_tag,
  input  logic [LINE_OFF_W-1:0] miss_index,
  input  logic [NWAY_W-1:0]     way_select_bin,
  output logic                  busy,
  output logic                  fill_done,
  output logic                  mem_valid,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ready,
  output logic                  data_we,
  output logic [N_WAYS-1:0]     data_way_en,
  output logic [LINE_OFF_W-1:0] data_index,
  output logic [WORD_OFF_W-1:0] data_word_off,
  output logic [DATA_W-1:0]     data_wdata,
  output logic                  tag_we,
  output logic [N_WAYS-1:0]     tag_way_en,
  output logic [LINE_OFF_W-1:0] tag_index,
  output logic [TAG_W-1:0]      tag_wdata,
  output logic                  tag_valid,
  output logic                  rp_write_en,
  output logic [N_WAYS-1:0]     rp_way_hit,
  output logic [LINE_OFF_W-1:0] rp_line_addr
);

  localparam int BYTE_OFF_W = $clog2(DATA_W/8);

  fill_state_e           state, state_nxt;
  logic [TAG_W-1:0]      tag_r;
  logic [LINE_OFF_W-1:0] index_r;
  logic [NWAY_W-1:0]     way_r;
  logic [WORD_OFF_W-1:0] wcnt;
  logic [N_WAYS-1:0]     way_oh;

  cache_line_fill_bin_to_onehot #(.N_WAYS(N_WAYS), .NWAY_W(NWAY_W)) u_way_dec (
    .bin    (way_r),
    .onehot (way_oh)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tag_r   <= '0;
      index_r <= '0;
      way_r   <= '0;
      wcnt    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && miss_req) begin
        tag_r   <= miss_tag;
        index_r <= miss_index;
        way_r   <= way_select_bin;
        wcnt    <= '0;
      end
      // wraps to 0 after the last word of the line
      if (state == FETCH && mem_ready) wcnt <= wcnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt     = state;
    busy          = 1'b0;
    fill_done     = 1'b0;
    mem_valid     = 1'b0;
    mem_addr      = '0;
    data_we       = 1'b0;
    data_way_en   = '0;
    data_index    = '0;
    data_word_off = '0;
    data_wdata    = '0;
    tag_we        = 1'b0;
    tag_way_en    = '0;
    tag_index     = '0;
    tag_wdata     = '0;
    tag_valid     = 1'b0;
    rp_write_en   = 1'b0;
    rp_way_hit    = '0;
    rp_line_addr  = '0;
    case (state)
      IDLE: if (miss_req) state_nxt = INVAL;
      INVAL: begin
        busy       = 1'b1;
        tag_we     = 1'b1;
        tag_way_en = way_oh;
        tag_index  = index_r;
        tag_wdata  = tag_r;
        state_nxt  = FETCH;
      end
      FETCH: begin
        busy      = 1'b1;
        mem_valid = 1'b1;
        mem_addr  = ADDR_W'({tag_r, index_r, wcnt}) << BYTE_OFF_W;
        if (mem_ready) begin
          data_we       = 1'b1;
          data_way_en   = way_oh;
          data_index    = index_r;
          data_word_off = wcnt;
          data_wdata    = mem_rdata;
          if (&wcnt) state_nxt = COMMIT;
        end
      end
      COMMIT: begin
        busy         = 1'b1;
        tag_we       = 1'b1;
        tag_valid    = 1'b1;
        tag_way_en   = way_oh;
        tag_index    = index_r;
        tag_wdata    = tag_r;
        rp_write_en  = 1'b1;
        rp_way_hit   = way_oh;
        rp_line_addr = index_r;
        fill_done    = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_line_fill.sv
// Bench for cache_line_fill: directed scenarios plus random traffic, every cycle
// compared against a transaction-level model of the fill sequence.
module tb_cache_line_fill;

  localparam int N_WAYS = 4, NWAY_W = 2, LINE_OFF_W = 4, WORD_OFF_W = 2;
  localparam int DATA_W = 32, ADDR_W = 32, TAG_W = 24, WORDS = 4;

  logic                  clk = 1'b0, reset = 1'b1;
  logic                  miss_req = 1'b0;
  logic [TAG_W-1:0]      miss_tag = '0;
  logic [LINE_OFF_W-1:0] miss_index = '0;
  logic [NWAY_W-1:0]     way_select_bin = '0;
  logic                  busy, fill_done, mem_valid, mem_ready = 1'b0;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_rdata = '0, data_wdata;
  logic                  data_we, tag_we, tag_valid, rp_write_en;
  logic [N_WAYS-1:0]     data_way_en, tag_way_en, rp_way_hit;
  logic [LINE_OFF_W-1:0] data_index, tag_index, rp_line_addr;
  logic [WORD_OFF_W-1:0] data_word_off;
  logic [TAG_W-1:0]      tag_wdata;

  cache_line_fill #(.N_WAYS(N_WAYS), .NWAY_W(NWAY_W), .LINE_OFF_W(LINE_OFF_W),
    .WORD_OFF_W(WORD_OFF_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .miss_req(miss_req), .miss_tag(miss_tag),
    .miss_index(miss_index), .way_select_bin(way_select_bin), .busy(busy),
    .fill_done(fill_done), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .data_we(data_we),
    .data_way_en(data_way_en), .data_index(data_index), .data_word_off(data_word_off),
    .data_wdata(data_wdata), .tag_we(tag_we), .tag_way_en(tag_way_en),
    .tag_index(tag_index), .tag_wdata(tag_wdata), .tag_valid(tag_valid),
    .rp_write_en(rp_write_en), .rp_way_hit(rp_way_hit), .rp_line_addr(rp_line_addr)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;
  bit check_en = 0;
  int fd_cnt = 0, dwe_cnt = 0, tv_cnt = 0, rp_cnt = 0;
  bit inval_seen = 0;
  int inval_q[$], fd_q[$];

  // model: age = cycles since acceptance (0 = idle), words = words returned
  int m_age = 0, m_words = 0, m_idx = 0, m_way = 0;
  logic [TAG_W-1:0] m_tag = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (check_en) begin
      bit inval, fetching, commit, wr;
      logic [63:0] oh, e_addr;
      inval    = (m_age == 1);
      fetching = (m_age >= 2) && (m_words < WORDS);
      commit   = (m_age >= 2) && (m_words == WORDS);
      wr       = fetching && mem_ready;
      oh       = 64'd1 << m_way;
      e_addr   = fetching ? ((64'(m_tag) << 8) | (64'(m_idx) << 4) | (64'(m_words) << 2)) : 64'd0;
      chk("busy", busy, m_age != 0);
      chk("fill_done", fill_done, commit);
      chk("mem_valid", mem_valid, fetching);
      chk("mem_addr", mem_addr, e_addr);
      chk("data_we", data_we, wr);
      chk("data_way_en", data_way_en, wr ? oh : 0);
      chk("data_index", data_index, wr ? m_idx : 0);
      chk("data_word_off", data_word_off, wr ? m_words : 0);
      chk("data_wdata", data_wdata, wr ? mem_rdata : 0);
      chk("tag_we", tag_we, inval || commit);
      chk("tag_way_en", tag_way_en, (inval || commit) ? oh : 0);
      chk("tag_index", tag_index, (inval || commit) ? m_idx : 0);
      chk("tag_wdata", tag_wdata, (inval || commit) ? m_tag : 0);
      chk("tag_valid", tag_valid, commit);
      chk("rp_write_en", rp_write_en, commit);
      chk("rp_way_hit", rp_way_hit, commit ? oh : 0);
      chk("rp_line_addr", rp_line_addr, commit ? m_idx : 0);
      if (fill_done) begin fd_cnt++; fd_q.push_back(cyc); end
      if (data_we) dwe_cnt++;
      if (tag_we && tag_valid) tv_cnt++;
      if (rp_write_en) rp_cnt++;
      if (tag_we && !tag_valid) begin
        inval_q.push_back(cyc);
        if (tag_way_en == 4'b0100 && tag_index == 4'd5) inval_seen = 1;
      end
    end
    // inputs are stable from posedge+1 through the next edge
    if (reset) begin
      m_age = 0; m_words = 0;
    end else if (m_age == 0) begin
      if (miss_req) begin
        m_age = 1; m_words = 0; m_tag = miss_tag; m_idx = miss_index; m_way = way_select_bin;
      end
    end else if (m_age >= 2 && m_words == WORDS) begin
      m_age = 0;
    end else begin
      if (m_age >= 2 && mem_ready) m_words++;
      m_age++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    mem_rdata = $urandom;
  endtask

  task automatic start(input logic [TAG_W-1:0] t, input int idx, input int w);
    miss_req = 1'b1; miss_tag = t; miss_index = idx[LINE_OFF_W-1:0];
    way_select_bin = w[NWAY_W-1:0];
  endtask

  task automatic wait_fd(input int bound);
    int s, n;
    s = fd_cnt; n = 0;
    while (fd_cnt == s && n < bound) begin tick(); n++; end
    chk("fill completes in time", fd_cnt != s, 1);
  endtask

  initial begin
    int s_dwe, s_fd, tv0, rp0;
    tick();
    check_en = 1;
    tick();
    @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset fill_done", fill_done, 0);
    tick(); reset = 1'b0; tick();

    // zero-wait fill
    mem_ready = 1'b1;
    start(24'hABCDEF, 5, 2);
    tick(); miss_req = 1'b0;
    @(negedge clk);
    chk("c1 inval tag_we", tag_we, 1);
    chk("c1 inval tag_valid", tag_valid, 0);
    chk("c1 inval way", tag_way_en, 4'b0100);
    tick(); @(negedge clk);
    chk("c2 mem_addr", mem_addr, 32'hABCDEF50);
    chk("c2 data_way_en", data_way_en, 4'b0100);
    tick(); tick(); tick(); @(negedge clk);
    chk("c5 mem_addr", mem_addr, 32'hABCDEF5C);
    chk("c5 word_off", data_word_off, 3);
    tick(); @(negedge clk);
    chk("c6 fill_done", fill_done, 1);
    chk("c6 tag_valid", tag_valid, 1);
    chk("c6 rp_way_hit", rp_way_hit, 4'b0100);
    chk("c6 rp_line_addr", rp_line_addr, 5);
    tick(); @(negedge clk);
    chk("c7 busy", busy, 0);

    // wait states: ready every third cycle
    s_dwe = dwe_cnt; s_fd = fd_cnt;
    mem_ready = 1'b0;
    start(24'h123456, 9, 1);
    tick(); miss_req = 1'b0;
    for (int n = 0; n < 40; n++) begin
      mem_ready = (n % 3 == 2);
      tick();
    end
    mem_ready = 1'b0;
    chk("wait data_we pulses", dwe_cnt - s_dwe, 4);
    chk("wait fill_done count", fd_cnt - s_fd, 1);

    // way changes mid-fill must not leak into the enables
    mem_ready = 1'b1;
    start(24'h0A0B0C, 2, 1);
    tick(); miss_req = 1'b0;
    tick(); tick(); way_select_bin = 2'd3;
    @(negedge clk);
    chk("way latch data_way_en", data_way_en, 4'b0010);
    wait_fd(20);

    // request while busy is held off until the IDLE cycle after COMMIT
    start(24'h111111, 3, 0);
    tick(); miss_req = 1'b0;
    tick(); start(24'h222222, 7, 3);
    wait_fd(20);
    @(negedge clk);
    chk("busy after commit", busy, 0);
    tick(); miss_req = 1'b0; @(negedge clk);
    chk("held req inval tag", tag_wdata, 24'h222222);
    chk("held req inval way", tag_way_en, 4'b1000);
    wait_fd(20);
    tick();

    // reset after word 1
    inval_seen = 0;
    start(24'h0F0F0F, 5, 2);
    tick(); miss_req = 1'b0;
    tick(); tick(); tick();
    tv0 = tv_cnt; rp0 = rp_cnt; reset = 1'b1;
    tick(); reset = 1'b0; @(negedge clk);
    chk("post-reset busy", busy, 0);
    chk("post-reset mem_valid", mem_valid, 0);
    chk("post-reset data_we", data_we, 0);
    for (int n = 0; n < 8; n++) tick();
    chk("no commit after reset", tv_cnt - tv0, 0);
    chk("no rp write after reset", rp_cnt - rp0, 0);
    chk("inval observed", inval_seen, 1);

    // back-to-back
    inval_q.delete(); fd_q.delete();
    start(24'h333333, 1, 3);
    for (int n = 0; n < 9; n++) tick();
    miss_req = 1'b0;
    for (int n = 0; n < 20; n++) tick();
    if (inval_q.size() >= 2 && fd_q.size() >= 2) begin
      chk("b2b inval spacing", inval_q[1] - inval_q[0], 7);
      chk("b2b fill_done spacing", fd_q[1] - fd_q[0], 7);
    end else begin
      chk("b2b event count", inval_q.size() >= 2 && fd_q.size() >= 2, 1);
    end

    // random traffic
    for (int n = 0; n < 2000; n++) begin
      miss_req       = ($urandom % 3 == 0);
      miss_tag       = TAG_W'($urandom);
      miss_index     = LINE_OFF_W'($urandom);
      way_select_bin = NWAY_W'($urandom);
      mem_ready      = ($urandom % 2 == 0);
      reset          = ($urandom % 150 == 0);
      tick();
    end
    reset = 1'b0; miss_req = 1'b0;
    for (int n = 0; n < 5; n++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
